// File: rtl/mod_counter_pkg.sv
// Shared definitions for mod_counter: direction encoding and the prescaler tick-width helper.
package mod_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // A PRESCALE of 1 still gets a 1-bit tick so the register never collapses to zero width.
  function automatic int unsigned tick_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Enable-gated tick counter (0..PRESCALE-1); tick_out marks the cycle on which the parent may step.
module mod_counter_prescaler
  import mod_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick_out
);

  localparam int unsigned     TW       = tick_width(PRESCALE);
  localparam logic [TW-1:0]   TICK_MAX = TW'(PRESCALE - 1);
  localparam logic [TW-1:0]   TICK_ONE = TW'(1);

  logic [TW-1:0] tick_q, tick_d;

  always_comb begin
    tick_d = tick_q;
    if (clr) begin
      tick_d = '0;
    end else if (en) begin
      tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + TICK_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick_out = (tick_q == TICK_MAX);

endmodule

// File: rtl/mod_counter.sv
// Synchronous modulo-N up/down counter with load, cascade tc and registered wrap pulse.
// Optional prescaler compiled in with `define MOD_COUNTER_PRESCALE_EN.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_counter: PRESCALE must be at least 1");
  end

  // MODULUS == 2**WIDTH gives an all-ones MAX_CNT, so +1/-1 wrap natively in WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             step_qual;
  logic             step;
  logic             at_max;
  logic             at_zero;
  logic             wrap_now;
  dir_e             dir;

`ifdef MOD_COUNTER_PRESCALE_EN
  mod_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (load),
    .tick_out (step_qual)
  );
`else
  assign step_qual = 1'b1;
`endif

  assign dir      = dir_e'(up);
  assign at_max   = (q_q == MAX_CNT);
  assign at_zero  = (q_q == '0);
  assign step     = en & ~load & step_qual;
  assign wrap_now = step & (((dir == DIR_UP) & at_max) | ((dir == DIR_DOWN) & at_zero));

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = (load_val > MAX_CNT) ? MAX_CNT : load_val;
    end else if (step) begin
      wrap_d = wrap_now;
      if (dir == DIR_UP) begin
        q_d = at_max ? '0 : q_q + ONE;
      end else begin
        q_d = at_zero ? MAX_CNT : q_q - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign tc   = wrap_now;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: mod-10, natural-wrap mod-8 and a two-stage decimal cascade.
module tb_mod_counter;

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int PS = 3;
`else
  localparam int PS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset, en, up, load, ce;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, wrap;
  logic [2:0] q3;
  logic       tc3, wrap3;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, lo_wrap, hi_tc, hi_wrap;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(PS)) u_dut10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q), .tc(tc), .wrap(wrap));

  mod_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(PS)) u_dut8 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[2:0]),
    .q(q3), .tc(tc3), .wrap(wrap3));

  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(PS)) u_lo (
    .clk(clk), .reset(reset), .en(ce), .up(1'b1), .load(1'b0), .load_val(4'd0),
    .q(lo_q), .tc(lo_tc), .wrap(lo_wrap));

  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(PS)) u_hi (
    .clk(clk), .reset(reset), .en(lo_tc), .up(1'b1), .load(1'b0), .load_val(4'd0),
    .q(hi_q), .tc(hi_tc), .wrap(hi_wrap));

  typedef struct {
    logic tc; logic tc3; logic lo_tc; logic hi_tc;
  } pre_t;

  typedef struct {
    logic [3:0] q; logic wrap; logic [2:0] q3; logic wrap3;
    logic [3:0] lo; logic lo_wrap; logic [3:0] hi; logic hi_wrap;
  } post_t;

  pre_t  pre_q[$];
  post_t post_q[$];

  int checks = 0;
  int errors = 0;

  int mq = 0, mt = 0, m3q = 0, m3t = 0, lq = 0, lt = 0, hq = 0, ht = 0;
  bit mvalid = 1'b0;

  // Reference: one counter of modulus m with its own prescale tick; returns pre-edge tc and next wrap.
  task automatic mstep(input int m, input bit r, input bit e, input bit u, input bit l,
                       input int v, inout int cq, inout int ct, output bit tcx, output bit wr);
    bit term;
    term = (ct == PS - 1);
    tcx  = e && !l && term && (u ? (cq == m - 1) : (cq == 0));
    wr   = 1'b0;
    if (!r) begin
      cq = 0; ct = 0;
    end else if (l) begin
      cq = (v > m - 1) ? m - 1 : v;
      ct = 0;
    end else if (e) begin
      if (term) begin
        wr = tcx;
        cq = u ? (cq + 1) % m : (cq + m - 1) % m;
        ct = 0;
      end else begin
        ct = ct + 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit u, input bit l, input int v, input bit c);
    pre_t  p;
    post_t s;
    bit t, t3, tl, th, w, w3, wl, wh;
    @(negedge clk);
    reset = r; en = e; up = u; load = l; load_val = 4'(v); ce = c;
    mstep(10, r, e, u, l, v & 15, mq, mt, t, w);
    mstep(8, r, e, u, l, v & 7, m3q, m3t, t3, w3);
    mstep(10, r, c, 1'b1, 1'b0, 0, lq, lt, tl, wl);
    mstep(10, r, tl, 1'b1, 1'b0, 0, hq, ht, th, wh);
    if (mvalid) begin
      p.tc = t; p.tc3 = t3; p.lo_tc = tl; p.hi_tc = th;
      pre_q.push_back(p);
    end
    s.q = 4'(mq); s.wrap = w; s.q3 = 3'(m3q); s.wrap3 = w3;
    s.lo = 4'(lq); s.lo_wrap = wl; s.hi = 4'(hq); s.hi_wrap = wh;
    post_q.push_back(s);
    if (!r) mvalid = 1'b1;
  endtask

  // Monitor: combinational tc after inputs settle, registered state just after the edge.
  initial begin
    pre_t  p;
    post_t s;
    forever begin
      @(negedge clk);
      #2;
      if (pre_q.size() > 0) begin
        p = pre_q.pop_front();
        check("tc_m10", {7'd0, tc}, {7'd0, p.tc});
        check("tc_m8", {7'd0, tc3}, {7'd0, p.tc3});
        check("tc_casc_lo", {7'd0, lo_tc}, {7'd0, p.lo_tc});
        check("tc_casc_hi", {7'd0, hi_tc}, {7'd0, p.hi_tc});
      end
      @(posedge clk);
      #1;
      if (post_q.size() > 0) begin
        s = post_q.pop_front();
        check("q_m10", {4'd0, q}, {4'd0, s.q});
        check("wrap_m10", {7'd0, wrap}, {7'd0, s.wrap});
        check("q_m8", {5'd0, q3}, {5'd0, s.q3});
        check("wrap_m8", {7'd0, wrap3}, {7'd0, s.wrap3});
        check("casc_decimal", {hi_q, lo_q}, {s.hi, s.lo});
        check("wrap_casc_lo", {7'd0, lo_wrap}, {7'd0, s.lo_wrap});
        check("wrap_casc_hi", {7'd0, hi_wrap}, {7'd0, s.hi_wrap});
      end
    end
  end

  initial begin
    int k;
    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; ce = 1'b0;

    repeat (2) drive(0, 1, 1, 0, 0, 1);          // reset held with en=1
    repeat (12 * PS) drive(1, 1, 1, 0, 0, 1);    // up through 9 -> 0
    repeat (5 * PS) drive(1, 1, 0, 0, 0, 1);     // down through 0 -> 9, lands on 7
    repeat (PS) drive(1, 1, 1, 0, 0, 1);         // direction flip 7 -> 8
    drive(1, 0, 1, 1, 12, 1);                    // saturating load -> 9
    drive(1, 1, 1, 1, 5, 1);                     // load beats step at terminal
    drive(1, 1, 1, 1, 9, 1);
    repeat (PS) drive(1, 1, 1, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 1);                     // reset mid-count
    repeat (2) drive(1, 0, 1, 0, 0, 0);          // en low: hold
    repeat (PS + 1) drive(1, 1, 1, 0, 0, 1);
    repeat (2) drive(1, 0, 1, 0, 0, 0);          // en dropped mid-period
    repeat (110 * PS) drive(1, 1, 1, 0, 0, 1);   // cascade runs past 99
    repeat (400)
      drive($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 15)), $urandom_range(0, 4) != 0);

    k = 0;
    while ((pre_q.size() > 0 || post_q.size() > 0) && k < 10) begin
      @(posedge clk);
      k++;
    end
    #2;
    checks++;
    if (pre_q.size() > 0 || post_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", pre_q.size() + post_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
